ucc_param: RTL and testbench

Parametrised universal counter/shift register, the next generation of the team's 8-bit universal counter cell. It holds, counts up or down, loads in parallel, shifts in either direction, or clears synchronously. Counting wraps at a programmable modulus. Gated carry and borrow terminal-count outputs let N instances cascade into wider counters or divide-by-N chains. It sits in datapath and timer logic wherever a loadable, cascadable count or serial shift register is needed.

---
 rtl/ucc_pkg.sv | 15 +
 rtl/ucc_param.sv | 79 +++++++
 tb/tb_ucc_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ucc_pkg.sv
// rtl/ucc_pkg.sv - operation encoding shared by the universal counter cell and its users.
package ucc_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    UP   = 3'd1,
    DOWN = 3'd2,
    LOAD = 3'd3,
    SHL  = 3'd4,
    SHR  = 3'd5,
    CLR  = 3'd6,
    RSVD = 3'd7
  } mode_e;

endpackage

// File: rtl/ucc_param.sv
// rtl/ucc_param.sv - parametrised universal counter / shift register with modulus wrap.
// Carry/borrow outputs are combinational so instances cascade into wider counters.
module ucc_param
  import ucc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic             cen,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             zero,
  output logic             sout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    case (mode)
      UP: begin
        if (cen) begin
          // Out-of-range values (left by LOAD) also fold back to zero.
          if (q_q >= MAXV) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end
      end
      DOWN: begin
        if (cen) begin
          if (q_q == '0) begin
            q_d    = MAXV;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q - ONE;
          end
        end
      end
      LOAD:    q_d = pin;
      SHL:     q_d = {q_q[WIDTH-2:0], sin};
      SHR:     q_d = {sin, q_q[WIDTH-1:1]};
      CLR:     q_d = '0;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q     = q_q;
  assign wrap  = wrap_q;
  assign zero  = (q_q == '0);
  assign tc_up = (mode == UP) && cen && (q_q >= MAXV);
  assign tc_dn = (mode == DOWN) && cen && (q_q == '0);
  assign sout  = (mode == SHL) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_ucc_param.sv
// tb/tb_ucc_param.sv - self-checking bench for ucc_param: vector tables, random ops vs. arithmetic model, cascade.
module tb_ucc_param;
  import ucc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, full-range instance
  mode_e mode8 = HOLD;
  logic cen8 = 0, sin8 = 0;
  logic [7:0] pin8 = '0, q8;
  logic tcu8, tcd8, zero8, sout8, wrap8;
  ucc_param #(.WIDTH(8), .MODULUS(256)) u8 (
    .clk(clk), .rst(rst), .mode(mode8), .cen(cen8), .sin(sin8), .pin(pin8),
    .q(q8), .tc_up(tcu8), .tc_dn(tcd8), .zero(zero8), .sout(sout8), .wrap(wrap8));

  // 4-bit, modulus-10 instance
  mode_e mode4 = HOLD;
  logic cen4 = 0, sin4 = 0;
  logic [3:0] pin4 = '0, q4;
  logic tcu4, tcd4, zero4, sout4, wrap4;
  ucc_param #(.WIDTH(4), .MODULUS(10)) u4 (
    .clk(clk), .rst(rst), .mode(mode4), .cen(cen4), .sin(sin4), .pin(pin4),
    .q(q4), .tc_up(tcu4), .tc_dn(tcd4), .zero(zero4), .sout(sout4), .wrap(wrap4));

  // two cascaded 4-bit modulus-16 stages
  mode_e modec = HOLD;
  logic cen_lo = 0;
  logic [3:0] pin_lo = '0, pin_hi = '0, q_lo, q_hi;
  logic tcu_lo, tcd_lo, z_lo, so_lo, wr_lo, tcu_hi, tcd_hi, z_hi, so_hi, wr_hi;
  logic cen_hi;
  assign cen_hi = tcu_lo;
  ucc_param #(.WIDTH(4), .MODULUS(16)) c_lo (
    .clk(clk), .rst(rst), .mode(modec), .cen(cen_lo), .sin(1'b0), .pin(pin_lo),
    .q(q_lo), .tc_up(tcu_lo), .tc_dn(tcd_lo), .zero(z_lo), .sout(so_lo), .wrap(wr_lo));
  ucc_param #(.WIDTH(4), .MODULUS(16)) c_hi (
    .clk(clk), .rst(rst), .mode(modec), .cen(cen_hi), .sin(1'b0), .pin(pin_hi),
    .q(q_hi), .tc_up(tcu_hi), .tc_dn(tcd_hi), .zero(z_hi), .sout(so_hi), .wrap(wr_hi));

  int total = 0;
  int bad = 0;
  int mq8 = 0, mw8 = 0, mq4 = 0, mw4 = 0;

  typedef struct {
    mode_e m;
    bit    c;
    bit    s;
    int    p;
    int    exp_q;
    int    exp_w;
  } vec_t;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_next(int q, mode_e m, bit c, bit s, int p, int w, int md);
    case (m)
      UP:      return c ? ((q >= md - 1) ? 0 : q + 1) : q;
      DOWN:    return c ? ((q == 0) ? md - 1 : q - 1) : q;
      LOAD:    return p;
      SHL:     return (q * 2 + s) % (2 ** w);
      SHR:     return s * (2 ** (w - 1)) + q / 2;
      CLR:     return 0;
      default: return q;
    endcase
  endfunction

  function automatic int ref_wrap(int q, mode_e m, bit c, int md);
    return int'((m == UP && c && q >= md - 1) || (m == DOWN && c && q == 0));
  endfunction

  task automatic step8(mode_e m, bit c, bit s, int p);
    mode8 = m; cen8 = c; sin8 = s; pin8 = p[7:0];
    #1;
    chk("u8_q_pre", int'(q8), mq8);
    chk("u8_zero", int'(zero8), int'(mq8 == 0));
    chk("u8_tc_up", int'(tcu8), int'(m == UP && c && mq8 >= 255));
    chk("u8_tc_dn", int'(tcd8), int'(m == DOWN && c && mq8 == 0));
    chk("u8_sout", int'(sout8), (m == SHL) ? (mq8 / 128) % 2 : mq8 % 2);
    @(posedge clk); #1;
    mw8 = ref_wrap(mq8, m, c, 256);
    mq8 = ref_next(mq8, m, c, s, p % 256, 8, 256);
    chk("u8_q", int'(q8), mq8);
    chk("u8_wrap", int'(wrap8), mw8);
    mode8 = HOLD;
  endtask

  task automatic step4(mode_e m, bit c, bit s, int p);
    mode4 = m; cen4 = c; sin4 = s; pin4 = p[3:0];
    #1;
    chk("u4_q_pre", int'(q4), mq4);
    chk("u4_zero", int'(zero4), int'(mq4 == 0));
    chk("u4_tc_up", int'(tcu4), int'(m == UP && c && mq4 >= 9));
    chk("u4_tc_dn", int'(tcd4), int'(m == DOWN && c && mq4 == 0));
    chk("u4_sout", int'(sout4), (m == SHL) ? (mq4 / 8) % 2 : mq4 % 2);
    @(posedge clk); #1;
    mw4 = ref_wrap(mq4, m, c, 10);
    mq4 = ref_next(mq4, m, c, s, p % 16, 4, 10);
    chk("u4_q", int'(q4), mq4);
    chk("u4_wrap", int'(wrap4), mw4);
    mode4 = HOLD;
  endtask

  vec_t t8[$];
  vec_t t4[$];

  initial begin
    int v;
    t8 = '{
      '{LOAD, 0, 0, 'hA5, 'hA5, 0}, '{SHL, 0, 1, 0, 'h4B, 0}, '{SHL, 1, 1, 0, 'h97, 0},
      '{SHL, 0, 1, 0, 'h2F, 0}, '{LOAD, 0, 0, 'hA5, 'hA5, 0}, '{SHR, 1, 0, 0, 'h52, 0},
      '{SHR, 0, 0, 0, 'h29, 0}, '{LOAD, 0, 0, 'hFF, 'hFF, 0}, '{UP, 0, 0, 0, 'hFF, 0},
      '{UP, 1, 0, 0, 'h00, 1}, '{UP, 0, 0, 0, 'h00, 0}, '{UP, 1, 0, 0, 'h01, 0},
      '{UP, 0, 0, 0, 'h01, 0}, '{DOWN, 1, 0, 0, 'h00, 0}, '{DOWN, 1, 0, 0, 'hFF, 1},
      '{RSVD, 1, 1, 7, 'hFF, 0}, '{CLR, 0, 0, 0, 'h00, 0}
    };
    t4 = '{
      '{LOAD, 0, 0, 3, 3, 0}, '{DOWN, 1, 0, 0, 2, 0}, '{DOWN, 1, 0, 0, 1, 0},
      '{DOWN, 1, 0, 0, 0, 0}, '{DOWN, 0, 0, 0, 0, 0}, '{DOWN, 1, 0, 0, 9, 1},
      '{DOWN, 1, 0, 0, 8, 0}, '{UP, 1, 0, 0, 9, 0}, '{UP, 1, 0, 0, 0, 1},
      '{LOAD, 1, 0, 13, 13, 0}, '{UP, 1, 0, 0, 0, 1}, '{LOAD, 0, 0, 14, 14, 0},
      '{DOWN, 1, 0, 0, 13, 0}, '{SHL, 0, 1, 0, 11, 0}, '{SHR, 0, 1, 0, 13, 0}
    };

    // reset state, including tc_dn following mode/cen while q is held at zero
    mode8 = DOWN; cen8 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(q8), 0);
    chk("rst_zero", int'(zero8), 1);
    chk("rst_wrap", int'(wrap8), 0);
    chk("rst_tc_up", int'(tcu8), 0);
    chk("rst_tc_dn", int'(tcd8), 1);
    chk("rst_q4", int'(q4), 0);
    mode8 = HOLD; cen8 = 0;
    @(negedge clk) rst = 0;

    // count, then reset mid-count asynchronously
    for (int i = 0; i < 40; i++) step8(UP, 1, 0, 0);
    mode8 = UP; cen8 = 1;
    rst = 1;
    #1;
    chk("async_rst_q", int'(q8), 0);
    chk("async_rst_zero", int'(zero8), 1);
    chk("async_rst_wrap", int'(wrap8), 0);
    mq8 = 0; mw8 = 0; mq4 = 0; mw4 = 0;
    @(posedge clk); #1;
    chk("held_rst_q", int'(q8), 0);
    mode8 = HOLD;
    @(negedge clk) rst = 0;

    // 300 up-count cycles across the 255->0 wrap
    for (int i = 0; i < 300; i++) step8(UP, 1, 0, 0);
    // cen toggling
    for (int i = 0; i < 8; i++) step8(UP, i % 2 == 0, 0, 0);

    foreach (t8[i]) begin
      step8(t8[i].m, t8[i].c, t8[i].s, t8[i].p);
      chk($sformatf("t8_q[%0d]", i), int'(q8), t8[i].exp_q);
      chk($sformatf("t8_wrap[%0d]", i), int'(wrap8), t8[i].exp_w);
    end
    foreach (t4[i]) begin
      step4(t4[i].m, t4[i].c, t4[i].s, t4[i].p);
      chk($sformatf("t4_q[%0d]", i), int'(q4), t4[i].exp_q);
      chk($sformatf("t4_wrap[%0d]", i), int'(wrap4), t4[i].exp_w);
    end

    // random operations against the arithmetic model
    for (int i = 0; i < 400; i++)
      step8(mode_e'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    for (int i = 0; i < 400; i++)
      step4(mode_e'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

    // cascade: {hi,lo} behaves as one 8-bit counter
    modec = LOAD; pin_lo = 4'hE; pin_hi = 4'h0;
    @(posedge clk); #1;
    chk("casc_load", int'({q_hi, q_lo}), 'h0E);
    v = 'h0E;
    modec = UP; cen_lo = 1;
    #1;
    chk("casc_tc_lo_0E", int'(tcu_lo), 0);
    @(posedge clk); #1;
    chk("casc_0F", int'({q_hi, q_lo}), 'h0F);
    chk("casc_tc_lo_0F", int'(tcu_lo), 1);
    @(posedge clk); #1;
    chk("casc_10", int'({q_hi, q_lo}), 'h10);
    v = 'h10;
    for (int i = 0; i < 60; i++) begin
      cen_lo = 1'($urandom_range(0, 3) != 0);
      #1;
      chk("casc_tc_lo", int'(tcu_lo), int'(cen_lo && v % 16 == 15));
      chk("casc_tc_hi", int'(tcu_hi), int'(cen_lo && v == 255));
      @(posedge clk); #1;
      v = cen_lo ? (v + 1) % 256 : v;
      chk("casc_q", int'({q_hi, q_lo}), v);
    end
    modec = HOLD; cen_lo = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
